// File: rtl/rr_mux4_arbiter_if.sv
// Bundle for the four-requester shared-mux arbiter: requests and data in, grant/select/mux out.
// slave is the arbiter side, master is the producer/consumer side.
interface rr_mux4_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic [3:0]        gnt;
  logic              s1;
  logic              s0;
  logic              busy;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, s1, s0, busy, out_data, out_valid
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, s1, s0, busy, out_data, out_valid
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, with a per-grant hold
// limit that forces a handoff when others are waiting.
module rr_mux4_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  rr_mux4_arbiter_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic [3:0] gnt_q;
  logic       busy_q;
  logic [7:0] hold_q;

  // First requester at or after start in rotating order; result is don't-care when r == 0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  logic [3:0] req;
  logic [1:0] next_ptr;
  logic [3:0] own_mask;
  logic       own_req;
  logic       others;
  logic [1:0] win_idle;
  logic [1:0] win_rel;
  logic       hold_full;

  assign req       = bus.req;
  assign next_ptr  = sel_q + 2'd1;
  assign own_mask  = 4'b0001 << sel_q;
  assign own_req   = req[sel_q];
  assign others    = |(req & ~own_mask);
  assign win_idle  = pick(req, ptr_q);
  assign win_rel   = pick(req, next_ptr);
  assign hold_full = (hold_q == HoldMax);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q <= StGrant;
            sel_q   <= win_idle;
            gnt_q   <= 4'b0001 << win_idle;
            busy_q  <= 1'b1;
            hold_q  <= 8'd1;
          end
        end
        StGrant: begin
          if (!own_req) begin
            // Voluntary release: hand off at this same edge if anyone else wants the mux.
            ptr_q <= next_ptr;
            if (others) begin
              sel_q  <= win_rel;
              gnt_q  <= 4'b0001 << win_rel;
              hold_q <= 8'd1;
            end else begin
              state_q <= StIdle;
              gnt_q   <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else if (hold_full && others) begin
            // Owner still asserting but out of budget; the owner sorts last from next_ptr.
            ptr_q  <= next_ptr;
            sel_q  <= win_rel;
            gnt_q  <= 4'b0001 << win_rel;
            hold_q <= 8'd1;
          end else if (!hold_full) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] mux_data;

  always_comb begin
    mux_data = '0;
    if (busy_q) begin
      unique case (sel_q)
        2'd0: mux_data = bus.d0;
        2'd1: mux_data = bus.d1;
        2'd2: mux_data = bus.d2;
        2'd3: mux_data = bus.d3;
        default: mux_data = '0;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.busy      = busy_q;
  assign bus.out_data  = mux_data;
  assign bus.out_valid = busy_q & req[sel_q];

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench: stimulus updates a behavioural arbiter model and queues expected state;
// a negedge monitor pops and compares against the DUT.
module tb_rr_mux4_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_mux4_arbiter_if #(.DATA_W(DW)) bus ();

  rr_mux4_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t q[$];

  // Model state: owner is -1 when nobody holds the mux.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;

  logic [3:0]    cur_req = 4'b0000;
  logic [DW-1:0] cur_d[4];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done  = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input logic [3:0] r);
    int g;
    int others;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = first_from(r, m_ptr);
        m_sel   = m_owner;
        m_hold  = 1;
      end
    end else begin
      g = m_owner;
      others = ((r & ~(4'b0001 << g)) != 4'b0000);
      if (!r[g]) begin
        m_ptr = (g + 1) % 4;
        if (others) begin
          m_owner = first_from(r, m_ptr);
          m_sel   = m_owner;
          m_hold  = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_hold == int'(MH) && others) begin
        m_ptr   = (g + 1) % 4;
        m_owner = first_from(r, m_ptr);
        m_sel   = m_owner;
        m_hold  = 1;
      end else if (m_hold < int'(MH)) begin
        m_hold++;
      end
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] r,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic [DW-1:0] d);
    exp_t e;
    rst_n   = rst ? 1'b0 : 1'b1;
    bus.req = r;
    bus.d0  = a;
    bus.d1  = b;
    bus.d2  = c;
    bus.d3  = d;
    cur_req = r;
    cur_d[0] = a; cur_d[1] = b; cur_d[2] = c; cur_d[3] = d;
    model_edge(rst, r);
    e.gnt  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input bit rst, input logic [3:0] r);
    step(rst, r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    forever begin
      @(negedge clk);
      if (done) break;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
      end else begin
        e = q.pop_front();
        exp_data  = e.busy ? cur_d[e.sel] : '0;
        exp_valid = e.busy & cur_req[e.sel];
        chk("gnt",       32'(bus.gnt),             32'(e.gnt));
        chk("sel",       32'({bus.s1, bus.s0}),    32'(e.sel));
        chk("busy",      32'(bus.busy),            32'(e.busy));
        chk("out_data",  32'(bus.out_data),        32'(exp_data));
        chk("out_valid", 32'(bus.out_valid),       32'(exp_valid));
        chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'(1));
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] r;
    rstep(1'b1, 4'b0000);
    rstep(1'b1, 4'b0000);
    // Idle after reset
    for (int i = 0; i < 5; i++) rstep(1'b0, 4'b0000);
    // Single requester 2 with fixed data, then drop
    for (int i = 0; i < 11; i++) step(1'b0, 4'b0100, 8'($urandom), 8'($urandom), 8'hA5,
                                      8'($urandom));
    for (int i = 0; i < 3; i++) rstep(1'b0, 4'b0000);
    // Fairness with all four requesting
    rstep(1'b1, 4'b0000);
    for (int i = 0; i < 22; i++) rstep(1'b0, 4'b1111);
    // Voluntary handoff: 1 granted, then 0011, then req[1] dropped
    rstep(1'b1, 4'b0000);
    rstep(1'b0, 4'b0010);
    rstep(1'b0, 4'b0011);
    rstep(1'b0, 4'b0011);
    for (int i = 0; i < 4; i++) rstep(1'b0, 4'b0001);
    rstep(1'b0, 4'b1101);
    rstep(1'b0, 4'b0000);
    // Reset mid-grant while requester 3 holds with hold count 3
    rstep(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) rstep(1'b0, 4'b1000);
    rstep(1'b1, 4'b1001);
    for (int i = 0; i < 4; i++) rstep(1'b0, 4'b1001);
    // Lone holder saturates, then a second requester appears
    rstep(1'b1, 4'b0000);
    for (int i = 0; i < 7; i++) rstep(1'b0, 4'b0001);
    for (int i = 0; i < 8; i++) rstep(1'b0, 4'b0011);
    // Random traffic with occasional resets
    r = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      rstep($urandom_range(0, 79) == 0, r);
    end
    rstep(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    done = 1'b1;
    chk("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
